i_cache: RTL and testbench
==========================

I_CACHE -- requirements
Module: i_cache

Interface
REQ-001 Parameter SETS, default 64, meaning number of direct-mapped lines (power of two, >=2); block = 256 bits = 8 words.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 Instr_address_2IC  input  32  fetch PC from IF; bits [1:0] ignored.
REQ-005 Instr1_fIC  output  32  instruction word at Instr_address_2IC.
REQ-006 Instr2_fIC  output  32  word at Instr_address_2IC+4 within same block; 0 when offset==7.
REQ-007 Instr_valid_fIC  output  1  Instr1/Instr2 valid this cycle; IF stalls while low.
REQ-008 Flush_2IC  input  1  invalidate all lines.
REQ-009 Instr_address_2IM  output  32  block-aligned fill address.
REQ-010 iBlkRead  output  1  block read request to instruction memory.
REQ-011 block_read_fIM  input  256  fill data; word i at bits [32i+31:32i], word 0 = lowest address.
REQ-012 block_read_fIM_valid  input  1  fill data valid this cycle.

Function
REQ-013 Address split SHALL be offset=[4:2], index=[4+log2(SETS):5], tag=remaining upper bits.
REQ-014 Hit SHALL be state==IDLE && valid[index] && tag[index]==addr tag && !Flush_2IC; lookup is combinational, zero-cycle latency.
REQ-015 On hit, Instr_valid_fIC=1 and Instr1/Instr2 SHALL come from the stored line in the same cycle; otherwise both 0 and Instr_valid_fIC=0.
REQ-016 States SHALL be IDLE and FILL only.
REQ-017 IDLE, miss, no flush: register {addr[31:5],5'b0} as fill address, go FILL next cycle.
REQ-018 FILL: iBlkRead=1, Instr_address_2IM=registered fill address (held constant), Instr_valid_fIC=0.
REQ-019 FILL with block_read_fIM_valid=1: write data+tag, set valid, return to IDLE; same address hits the following cycle.
REQ-020 block_read_fIM_valid in IDLE SHALL be ignored.
REQ-021 Change of Instr_address_2IC during FILL (branch redirect) SHALL NOT abort the fill; new address looked up once back in IDLE.
REQ-022 Outside FILL, iBlkRead=0 and Instr_address_2IM=0.
REQ-023 Flush_2IC in IDLE: all valid bits cleared at that edge; no fill starts that cycle.
REQ-024 Flush_2IC during FILL: record pending flush; at fill completion clear all valid bits including the filled line; flush also concurrent with block_read_fIM_valid -> flush wins.
REQ-025 Worst-case miss penalty: 1 cycle + memory latency + 1 cycle.

Reset
REQ-026 While RESET==0 at an edge: state=IDLE, all valid bits=0, pending flush=0, fill address=0.
REQ-027 During/after reset: iBlkRead=0, Instr_valid_fIC=0 until a hit; reset mid-FILL abandons the fill and later block_read_fIM_valid is ignored.
REQ-028 Tag/data arrays need not be reset.

Structure
REQ-029 Shared package SHALL hold BLOCK_BITS=256, WORDS_PER_BLOCK=8, OFFSET_BITS=3, the IDLE/FILL state enum, and block word-select helpers.
REQ-030 Storage SHALL be one sub-module i_cache_array (tag+data+valid, combinational read, one write port, global invalidate); control FSM stays in i_cache.

Verification (SETS=64; 0x00400000 -> index 0, tag 0x800)
REQ-031 Reset, then addr 0x00400000 -> valid=0; next cycle iBlkRead=1, Instr_address_2IM=0x00400000; block_read_fIM_valid after 3 cycles with word0=0x3C011001 -> next cycle valid=1, Instr1_fIC=0x3C011001.
REQ-032 Then addr 0x0040001C -> same cycle valid=1, Instr1_fIC=word7, Instr2_fIC=0; no iBlkRead.
REQ-033 Conflict: 0x00400800 (index 0, tag 0x801) -> miss and refill; then 0x00400000 -> miss again with iBlkRead=1.
REQ-034 Flush_2IC pulse in IDLE with line resident -> next lookup of 0x00400000 misses, iBlkRead=1.
REQ-035 Flush_2IC during FILL, then block_read_fIM_valid -> return IDLE, next lookup of same address misses.
REQ-036 RESET=0 for one cycle mid-FILL -> iBlkRead=0 after that edge; late block_read_fIM_valid ignored; lookup still misses.

Source files
------------

// File: rtl/i_cache_pkg.sv
// Shared constants, FSM state encoding and block word-select helpers for the
// instruction cache.
package i_cache_pkg;

   localparam int BLOCK_BITS      = 256;
   localparam int WORDS_PER_BLOCK = 8;
   localparam int OFFSET_BITS     = 3;
   localparam int WORD_BITS       = 32;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   function automatic logic [WORD_BITS-1:0] block_word(
      input logic [BLOCK_BITS-1:0]  blk,
      input logic [OFFSET_BITS-1:0] idx
   );
      return blk[{idx, 5'b0} +: WORD_BITS];
   endfunction

   // Second fetch word stays inside the block; the last word has no successor.
   function automatic logic [WORD_BITS-1:0] block_next_word(
      input logic [BLOCK_BITS-1:0]  blk,
      input logic [OFFSET_BITS-1:0] idx
   );
      logic [OFFSET_BITS-1:0] nxt;
      nxt = idx + 3'd1;
      if (idx == 3'd7)
         return '0;
      return block_word(blk, nxt);
   endfunction

endpackage

// File: rtl/i_cache_array.sv
// Direct-mapped tag/data/valid storage: combinational read, one write port,
// and a global invalidate that takes priority over the write's valid bit.
module i_cache_array
   import i_cache_pkg::*;
#(
   parameter int SETS     = 64,
   parameter int IDX_BITS = $clog2(SETS),
   parameter int TAG_BITS = 32 - 5 - IDX_BITS
) (
   input  logic                  clk_sys,
   input  logic                  rst_b,
   input  logic [IDX_BITS-1:0]   rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [BLOCK_BITS-1:0] rd_data,
   input  logic                  wr_en,
   input  logic [IDX_BITS-1:0]   wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [BLOCK_BITS-1:0] wr_data,
   input  logic                  inv_all
);

   logic [SETS-1:0]       valid_q;
   logic [TAG_BITS-1:0]   tag_mem  [SETS];
   logic [BLOCK_BITS-1:0] data_mem [SETS];

   always_ff @(posedge clk_sys) begin
      if (!rst_b)
         valid_q <= '0;
      else if (inv_all)
         valid_q <= '0;
      else if (wr_en)
         valid_q[wr_index] <= 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped instruction cache with a two-state fill controller; returns
// the addressed word and its successor in the same cycle on a hit.
//
// state | meaning
// IDLE  | combinational lookup; a miss latches the block address
// FILL  | block read outstanding; completes on block_read_fIM_valid
module i_cache
   import i_cache_pkg::*;
#(
   parameter int SETS = 64
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [31:0]           Instr_address_2IC,
   output logic [31:0]           Instr1_fIC,
   output logic [31:0]           Instr2_fIC,
   output logic                  Instr_valid_fIC,
   input  logic                  Flush_2IC,
   output logic [31:0]           Instr_address_2IM,
   output logic                  iBlkRead,
   input  logic [BLOCK_BITS-1:0] block_read_fIM,
   input  logic                  block_read_fIM_valid
);

   localparam int IDX_BITS = $clog2(SETS);
   localparam int TAG_BITS = 32 - 5 - IDX_BITS;

   state_t state_q, state_d;
   logic [31:0] fill_addr_q, fill_addr_d;
   logic        flush_pend_q, flush_pend_d;

   logic [OFFSET_BITS-1:0] lk_offset;
   logic [IDX_BITS-1:0]    lk_index;
   logic [TAG_BITS-1:0]    lk_tag;
   logic [IDX_BITS-1:0]    fill_index;
   logic [TAG_BITS-1:0]    fill_tag;

   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [BLOCK_BITS-1:0] rd_data;
   logic                  wr_en;
   logic                  inv_all;
   logic                  hit;
   logic                  unused_addr_bits;

   assign lk_offset  = Instr_address_2IC[4:2];
   assign lk_index   = Instr_address_2IC[5 +: IDX_BITS];
   assign lk_tag     = Instr_address_2IC[31 -: TAG_BITS];
   assign fill_index = fill_addr_q[5 +: IDX_BITS];
   assign fill_tag   = fill_addr_q[31 -: TAG_BITS];
   assign unused_addr_bits = ^Instr_address_2IC[1:0];

   i_cache_array #(
      .SETS     (SETS),
      .IDX_BITS (IDX_BITS),
      .TAG_BITS (TAG_BITS)
   ) u_array (
      .clk_sys  (CLK),
      .rst_b    (RESET),
      .rd_index (lk_index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_index (fill_index),
      .wr_tag   (fill_tag),
      .wr_data  (block_read_fIM),
      .inv_all  (inv_all)
   );

   // Outputs are gated by RESET so nothing looks valid while reset is held.
   assign hit = RESET && (state_q == IDLE) && rd_valid && (rd_tag == lk_tag) && !Flush_2IC;

   assign Instr_valid_fIC   = hit;
   assign Instr1_fIC        = hit ? block_word(rd_data, lk_offset) : '0;
   assign Instr2_fIC        = hit ? block_next_word(rd_data, lk_offset) : '0;
   assign iBlkRead          = RESET && (state_q == FILL);
   assign Instr_address_2IM = iBlkRead ? fill_addr_q : '0;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q      <= IDLE;
         fill_addr_q  <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fill_addr_q  <= fill_addr_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fill_addr_d  = fill_addr_q;
      flush_pend_d = flush_pend_q;
      wr_en        = 1'b0;
      inv_all      = 1'b0;
      case (state_q)
         IDLE: begin
            if (Flush_2IC) begin
               inv_all = 1'b1;
            end else if (!hit) begin
               fill_addr_d = {Instr_address_2IC[31:5], 5'b0};
               state_d     = FILL;
            end
         end
         FILL: begin
            if (Flush_2IC)
               flush_pend_d = 1'b1;
            if (block_read_fIM_valid) begin
               // The line is still written, but a flush seen during the fill
               // clears it together with everything else.
               wr_en        = 1'b1;
               inv_all      = flush_pend_q || Flush_2IC;
               flush_pend_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_i_cache.sv
// Directed test of the instruction cache: hit/miss timing, conflict refill,
// flush in both states and reset during a fill.
module tb_i_cache;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [31:0]  Instr_address_2IC;
   logic [31:0]  Instr1_fIC;
   logic [31:0]  Instr2_fIC;
   logic         Instr_valid_fIC;
   logic         Flush_2IC;
   logic [31:0]  Instr_address_2IM;
   logic         iBlkRead;
   logic [255:0] block_read_fIM;
   logic         block_read_fIM_valid;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] BASE_A = 32'h3C011001;
   localparam logic [31:0] BASE_B = 32'h24020005;
   localparam logic [31:0] BASE_C = 32'h8C430010;

   i_cache #(.SETS(64)) dut (
      .CLK                  (CLK),
      .RESET                (RESET),
      .Instr_address_2IC    (Instr_address_2IC),
      .Instr1_fIC           (Instr1_fIC),
      .Instr2_fIC           (Instr2_fIC),
      .Instr_valid_fIC      (Instr_valid_fIC),
      .Flush_2IC            (Flush_2IC),
      .Instr_address_2IM    (Instr_address_2IM),
      .iBlkRead             (iBlkRead),
      .block_read_fIM       (block_read_fIM),
      .block_read_fIM_valid (block_read_fIM_valid)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] wrd(input logic [31:0] base, input int i);
      return base + 32'(i) * 32'h00010004;
   endfunction

   function automatic logic [255:0] mk_blk(input logic [31:0] base);
      logic [255:0] b;
      for (int i = 0; i < 8; i++)
         b[i*32 +: 32] = wrd(base, i);
      return b;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called just after the edge that entered FILL; returns after the
   // completing edge with inputs settled.
   task automatic fill(input int lat, input logic [31:0] base);
      repeat (lat) tick();
      block_read_fIM       = mk_blk(base);
      block_read_fIM_valid = 1'b1;
      tick();
      block_read_fIM_valid = 1'b0;
      #1;
   endtask

   initial begin
      RESET                = 1'b0;
      Instr_address_2IC    = '0;
      Flush_2IC            = 1'b0;
      block_read_fIM       = '0;
      block_read_fIM_valid = 1'b0;

      tick();
      check_eq("rst_rd", 32'(iBlkRead), 0);
      check_eq("rst_valid", 32'(Instr_valid_fIC), 0);
      tick();
      RESET = 1'b1;

      // Cold miss and fill
      Instr_address_2IC = 32'h00400000;
      #1;
      check_eq("cold_valid", 32'(Instr_valid_fIC), 0);
      check_eq("cold_instr1", Instr1_fIC, 0);
      check_eq("cold_rd_idle", 32'(iBlkRead), 0);
      tick();
      check_eq("fill_rd", 32'(iBlkRead), 1);
      check_eq("fill_addr", Instr_address_2IM, 32'h00400000);
      check_eq("fill_valid", 32'(Instr_valid_fIC), 0);
      fill(3, BASE_A);
      check_eq("hit_valid", 32'(Instr_valid_fIC), 1);
      check_eq("hit_instr1", Instr1_fIC, 32'h3C011001);
      check_eq("hit_instr2", Instr2_fIC, wrd(BASE_A, 1));
      check_eq("hit_rd", 32'(iBlkRead), 0);
      check_eq("hit_im_addr", Instr_address_2IM, 0);

      // Last word of the block and a mid-block word
      Instr_address_2IC = 32'h0040001C;
      #1;
      check_eq("w7_valid", 32'(Instr_valid_fIC), 1);
      check_eq("w7_instr1", Instr1_fIC, wrd(BASE_A, 7));
      check_eq("w7_instr2", Instr2_fIC, 0);
      Instr_address_2IC = 32'h0040000B;
      #1;
      check_eq("w2_instr1", Instr1_fIC, wrd(BASE_A, 2));
      check_eq("w2_instr2", Instr2_fIC, wrd(BASE_A, 3));
      tick();
      check_eq("hit_no_rd", 32'(iBlkRead), 0);

      // Conflict on index 0
      Instr_address_2IC = 32'h00400800;
      #1;
      check_eq("conf_miss", 32'(Instr_valid_fIC), 0);
      tick();
      check_eq("conf_rd", 32'(iBlkRead), 1);
      check_eq("conf_addr", Instr_address_2IM, 32'h00400800);
      fill(2, BASE_B);
      check_eq("conf_hit", Instr1_fIC, wrd(BASE_B, 0));
      Instr_address_2IC = 32'h00400000;
      #1;
      check_eq("evict_miss", 32'(Instr_valid_fIC), 0);
      tick();
      check_eq("evict_rd", 32'(iBlkRead), 1);
      check_eq("evict_addr", Instr_address_2IM, 32'h00400000);

      // Redirect during fill does not disturb it
      Instr_address_2IC = 32'h00400820;
      tick();
      check_eq("redir_rd", 32'(iBlkRead), 1);
      check_eq("redir_addr", Instr_address_2IM, 32'h00400000);
      fill(1, BASE_A);
      check_eq("redir_new_miss", 32'(Instr_valid_fIC), 0);
      Instr_address_2IC = 32'h00400000;
      #1;
      check_eq("redir_old_hit", 32'(Instr_valid_fIC), 1);
      check_eq("redir_old_data", Instr1_fIC, wrd(BASE_A, 0));

      // Fill data while IDLE is ignored
      block_read_fIM       = mk_blk(BASE_C);
      block_read_fIM_valid = 1'b1;
      tick();
      block_read_fIM_valid = 1'b0;
      #1;
      check_eq("idle_ign_data", Instr1_fIC, wrd(BASE_A, 0));
      check_eq("idle_ign_rd", 32'(iBlkRead), 0);

      // Flush in IDLE
      Flush_2IC = 1'b1;
      #1;
      check_eq("flush_gate", 32'(Instr_valid_fIC), 0);
      tick();
      Flush_2IC = 1'b0;
      #1;
      check_eq("flush_rd_none", 32'(iBlkRead), 0);
      check_eq("flush_miss", 32'(Instr_valid_fIC), 0);
      tick();
      check_eq("flush_refill", 32'(iBlkRead), 1);
      fill(0, BASE_A);
      check_eq("flush_rehit", 32'(Instr_valid_fIC), 1);

      // Flush during FILL is held until completion
      Instr_address_2IC = 32'h00400800;
      #1;
      tick();
      Flush_2IC = 1'b1;
      tick();
      Flush_2IC = 1'b0;
      fill(1, BASE_B);
      check_eq("pend_miss", 32'(Instr_valid_fIC), 0);
      check_eq("pend_rd_idle", 32'(iBlkRead), 0);
      tick();
      check_eq("pend_refill", 32'(iBlkRead), 1);
      check_eq("pend_addr", Instr_address_2IM, 32'h00400800);

      // Flush concurrent with fill data: flush wins
      Flush_2IC            = 1'b1;
      block_read_fIM       = mk_blk(BASE_B);
      block_read_fIM_valid = 1'b1;
      tick();
      Flush_2IC            = 1'b0;
      block_read_fIM_valid = 1'b0;
      #1;
      check_eq("conc_miss", 32'(Instr_valid_fIC), 0);
      tick();
      check_eq("conc_refill", 32'(iBlkRead), 1);
      fill(2, BASE_B);
      check_eq("conc_rehit", Instr1_fIC, wrd(BASE_B, 0));

      // Reset in the middle of a fill
      Instr_address_2IC = 32'h00401000;
      #1;
      tick();
      check_eq("mid_rd", 32'(iBlkRead), 1);
      check_eq("mid_addr", Instr_address_2IM, 32'h00401000);
      RESET = 1'b0;
      #1;
      check_eq("mid_rst_gate", 32'(iBlkRead), 0);
      tick();
      RESET                = 1'b1;
      Instr_address_2IC    = 32'h00400800;
      block_read_fIM       = mk_blk(BASE_C);
      block_read_fIM_valid = 1'b1;
      #1;
      check_eq("post_rst_rd", 32'(iBlkRead), 0);
      check_eq("post_rst_im", Instr_address_2IM, 0);
      check_eq("post_rst_miss", 32'(Instr_valid_fIC), 0);
      tick();
      block_read_fIM_valid = 1'b0;
      #1;
      check_eq("post_rst_fill", 32'(iBlkRead), 1);
      check_eq("post_rst_addr", Instr_address_2IM, 32'h00400800);
      check_eq("post_rst_nohit", 32'(Instr_valid_fIC), 0);
      fill(1, BASE_C);
      check_eq("final_hit", 32'(Instr_valid_fIC), 1);
      check_eq("final_data", Instr1_fIC, wrd(BASE_C, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
